// File: rtl/io_mux_pkg.sv
// Shared types and constants for the io_mux4 configuration controller.
package io_mux_pkg;

  localparam int FUN_SEL_W = 2;

  localparam logic [FUN_SEL_W-1:0] FUN_SEL_A = 2'b00;
  localparam logic [FUN_SEL_W-1:0] FUN_SEL_B = 2'b01;
  localparam logic [FUN_SEL_W-1:0] FUN_SEL_C = 2'b10;
  localparam logic [FUN_SEL_W-1:0] FUN_SEL_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/io_mux_cfg_ctrl_if.sv
// Valid/ready reconfiguration request channel with done/err completion pulses.
interface io_mux_cfg_ctrl_if #(
  parameter int PIN_AW = 4
) ();
  import io_mux_pkg::*;

  logic                 cfg_vld;
  logic                 cfg_rdy;
  logic [PIN_AW-1:0]    cfg_pin;
  logic [FUN_SEL_W-1:0] cfg_sel;
  logic                 cfg_done;
  logic                 cfg_err;

  modport master (
    output cfg_vld, cfg_pin, cfg_sel,
    input  cfg_rdy, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_vld, cfg_pin, cfg_sel,
    output cfg_rdy, cfg_done, cfg_err
  );

endinterface

// File: rtl/io_mux_guard_timer.sv
// 8-bit loadable down-counter; o_expire is high while the count sits at zero.
module io_mux_guard_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/io_mux_cfg_ctrl.sv
// Per-pin function-select controller with glitch-free gate/switch/settle sequencing.
// Optional sticky request lock when IO_MUX_CFG_LOCK_EN is defined.
module io_mux_cfg_ctrl
  import io_mux_pkg::*;
#(
  parameter int PIN_NUM   = 16,
  parameter int PIN_AW    = (PIN_NUM > 1) ? $clog2(PIN_NUM) : 1,
  parameter int GUARD_CYC = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  io_mux_cfg_ctrl_if.slave               cfg,
  output logic                           busy,
  output logic [FUN_SEL_W*PIN_NUM-1:0]   fun_sel_vec,
  output logic [PIN_NUM-1:0]             oe_gate_vec,
`ifdef IO_MUX_CFG_LOCK_EN
  input  logic                           cfg_lock,
`endif
  input  logic [PIN_AW-1:0]              rd_pin,
  output logic [FUN_SEL_W-1:0]           rd_sel
);

  state_t                         r_state;
  logic [FUN_SEL_W*PIN_NUM-1:0]   r_fun_sel;
  logic [PIN_NUM-1:0]             r_oe_gate;
  logic [PIN_AW-1:0]              r_pin;
  logic [FUN_SEL_W-1:0]           r_sel;
  logic                           r_rdy;
  logic                           r_done;
  logic                           r_err;
  logic                           r_busy;

  logic                           w_locked;
  logic                           w_pin_ok;
  logic [PIN_AW-1:0]              w_idx;
  logic [FUN_SEL_W-1:0]           w_cur_sel;
  logic                           w_accept;
  logic                           w_start;
  logic                           w_load;
  logic                           w_expire;
  logic                           w_rd_ok;
  logic [PIN_AW-1:0]              w_rd_idx;

`ifdef IO_MUX_CFG_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock <= 1'b0;
    end else if (cfg_lock) begin
      r_lock <= 1'b1;
    end
  end

  assign w_locked = r_lock;
`else
  assign w_locked = 1'b0;
`endif

  // Out-of-range indices are folded to 0 so the part-selects never leave the vector.
  assign w_pin_ok  = 32'(cfg.cfg_pin) < 32'(PIN_NUM);
  assign w_idx     = w_pin_ok ? cfg.cfg_pin : '0;
  assign w_cur_sel = r_fun_sel[{w_idx, 1'b0} +: FUN_SEL_W];
  assign w_accept  = cfg.cfg_vld & r_rdy;
  assign w_start   = w_accept & w_pin_ok & ~w_locked & (w_cur_sel != cfg.cfg_sel);
  assign w_load    = w_start | (r_state == SWITCH);

  io_mux_guard_timer u_guard_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (8'(GUARD_CYC - 1)),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_fun_sel <= '0;
      r_oe_gate <= '1;
      r_pin     <= '0;
      r_sel     <= FUN_SEL_A;
      r_rdy     <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b1;
          if (w_accept) begin
            r_pin <= cfg.cfg_pin;
            r_sel <= cfg.cfg_sel;
            if (!w_pin_ok || w_locked) begin
              r_err <= 1'b1;
            end else if (w_cur_sel == cfg.cfg_sel) begin
              r_done <= 1'b1;
            end else begin
              r_state          <= DRAIN;
              r_oe_gate[w_idx] <= 1'b0;
              r_busy           <= 1'b1;
              r_rdy            <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_expire) begin
            r_state <= SWITCH;
          end
        end
        SWITCH: begin
          r_fun_sel[{r_pin, 1'b0} +: FUN_SEL_W] <= r_sel;
          r_state <= SETTLE;
        end
        SETTLE: begin
          if (w_expire) begin
            r_state          <= IDLE;
            r_oe_gate[r_pin] <= 1'b1;
            r_busy           <= 1'b0;
            r_rdy            <= 1'b1;
            r_done           <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rd_ok  = 32'(rd_pin) < 32'(PIN_NUM);
  assign w_rd_idx = w_rd_ok ? rd_pin : '0;
  assign rd_sel   = w_rd_ok ? r_fun_sel[{w_rd_idx, 1'b0} +: FUN_SEL_W] : '0;

  assign cfg.cfg_rdy  = r_rdy;
  assign cfg.cfg_done = r_done;
  assign cfg.cfg_err  = r_err;
  assign busy         = r_busy;
  assign fun_sel_vec  = r_fun_sel;
  assign oe_gate_vec  = r_oe_gate;

endmodule

// File: tb/tb_io_mux_cfg_ctrl.sv
// Directed bench for io_mux_cfg_ctrl (PIN_NUM=16, PIN_AW=5, GUARD_CYC=4).
// Defining IO_MUX_CFG_LOCK_EN also exercises the sticky lock.
module tb_io_mux_cfg_ctrl;

  localparam int PN = 16;
  localparam int AW = 5;
  localparam int GC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic [2*PN-1:0] fun_sel_vec;
  logic [PN-1:0] oe_gate_vec;
  logic [AW-1:0] rd_pin = '0;
  logic [1:0]    rd_sel;
`ifdef IO_MUX_CFG_LOCK_EN
  logic          cfg_lock = 1'b0;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  io_mux_cfg_ctrl_if #(.PIN_AW(AW)) cfg_if ();

  io_mux_cfg_ctrl #(
    .PIN_NUM   (PN),
    .PIN_AW    (AW),
    .GUARD_CYC (GC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_if.slave),
    .busy        (busy),
    .fun_sel_vec (fun_sel_vec),
    .oe_gate_vec (oe_gate_vec),
`ifdef IO_MUX_CFG_LOCK_EN
    .cfg_lock    (cfg_lock),
`endif
    .rd_pin      (rd_pin),
    .rd_sel      (rd_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge (the acceptance edge T) and returns in cycle T+1.
  task automatic send(input logic [AW-1:0] pin, input logic [1:0] sel);
    cfg_if.cfg_pin = pin;
    cfg_if.cfg_sel = sel;
    cfg_if.cfg_vld = 1'b1;
    tick();
    cfg_if.cfg_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_if.cfg_vld = 1'b0;
    tick(); tick();
    n_vec++; if (fun_sel_vec !== 32'h0) begin n_err++; $display("FAIL rst_sel: got %h expected %h", fun_sel_vec, 32'h0); end
    n_vec++; if (oe_gate_vec !== 16'hFFFF) begin n_err++; $display("FAIL rst_gate: got %h expected %h", oe_gate_vec, 16'hFFFF); end
    n_vec++; if (cfg_if.cfg_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b expected 0", cfg_if.cfg_rdy); end
    n_vec++; if ({cfg_if.cfg_done, cfg_if.cfg_err, busy} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {cfg_if.cfg_done, cfg_if.cfg_err, busy}); end
    rst = 1'b0;
    tick();
    n_vec++; if (cfg_if.cfg_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy_after: got %b expected 1", cfg_if.cfg_rdy); end
  endtask

  task automatic test_switch();
    logic [15:0] eg;
    logic [31:0] es;
    n_vec++; if (cfg_if.cfg_rdy !== 1'b1) begin n_err++; $display("FAIL sw_rdy_pre: got %b expected 1", cfg_if.cfg_rdy); end
    send(5'd3, 2'b10);
    for (int c = 1; c <= 11; c++) begin
      eg = (c <= 9) ? 16'hFFF7 : 16'hFFFF;
      es = (c >= 6) ? 32'h0000_0080 : 32'h0;
      n_vec++; if (oe_gate_vec !== eg) begin n_err++; $display("FAIL sw_gate c=%0d: got %h expected %h", c, oe_gate_vec, eg); end
      n_vec++; if (fun_sel_vec !== es) begin n_err++; $display("FAIL sw_sel c=%0d: got %h expected %h", c, fun_sel_vec, es); end
      n_vec++; if (cfg_if.cfg_done !== (c == 10)) begin n_err++; $display("FAIL sw_done c=%0d: got %b expected %b", c, cfg_if.cfg_done, (c == 10)); end
      n_vec++; if (cfg_if.cfg_rdy !== (c >= 10)) begin n_err++; $display("FAIL sw_rdy c=%0d: got %b expected %b", c, cfg_if.cfg_rdy, (c >= 10)); end
      n_vec++; if (busy !== (c <= 9)) begin n_err++; $display("FAIL sw_busy c=%0d: got %b expected %b", c, busy, (c <= 9)); end
      if (c < 11) tick();
    end
  endtask

  task automatic test_same_sel();
    send(5'd5, 2'b00);
    n_vec++; if (cfg_if.cfg_done !== 1'b1) begin n_err++; $display("FAIL same_done: got %b expected 1", cfg_if.cfg_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL same_busy: got %b expected 0", busy); end
    n_vec++; if (oe_gate_vec !== 16'hFFFF) begin n_err++; $display("FAIL same_gate: got %h expected %h", oe_gate_vec, 16'hFFFF); end
    n_vec++; if (cfg_if.cfg_rdy !== 1'b1) begin n_err++; $display("FAIL same_rdy: got %b expected 1", cfg_if.cfg_rdy); end
    tick();
    n_vec++; if (cfg_if.cfg_done !== 1'b0) begin n_err++; $display("FAIL same_done_end: got %b expected 0", cfg_if.cfg_done); end
    n_vec++; if (fun_sel_vec !== 32'h0000_0080) begin n_err++; $display("FAIL same_sel: got %h expected %h", fun_sel_vec, 32'h0000_0080); end
  endtask

  task automatic test_bad_pin();
    send(5'd16, 2'b01);
    n_vec++; if (cfg_if.cfg_err !== 1'b1) begin n_err++; $display("FAIL bad_err: got %b expected 1", cfg_if.cfg_err); end
    n_vec++; if (cfg_if.cfg_done !== 1'b0) begin n_err++; $display("FAIL bad_done: got %b expected 0", cfg_if.cfg_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bad_busy: got %b expected 0", busy); end
    n_vec++; if (oe_gate_vec !== 16'hFFFF) begin n_err++; $display("FAIL bad_gate: got %h expected %h", oe_gate_vec, 16'hFFFF); end
    n_vec++; if (fun_sel_vec !== 32'h0000_0080) begin n_err++; $display("FAIL bad_sel: got %h expected %h", fun_sel_vec, 32'h0000_0080); end
    tick();
    n_vec++; if (cfg_if.cfg_err !== 1'b0) begin n_err++; $display("FAIL bad_err_end: got %b expected 0", cfg_if.cfg_err); end
  endtask

  task automatic test_readback();
    rd_pin = 5'd3;  #1;
    n_vec++; if (rd_sel !== 2'b10) begin n_err++; $display("FAIL rd_pin3: got %b expected 10", rd_sel); end
    rd_pin = 5'd5;  #1;
    n_vec++; if (rd_sel !== 2'b00) begin n_err++; $display("FAIL rd_pin5: got %b expected 00", rd_sel); end
    rd_pin = 5'd19; #1;
    n_vec++; if (rd_sel !== 2'b00) begin n_err++; $display("FAIL rd_oor: got %b expected 00", rd_sel); end
    rd_pin = 5'd3;
  endtask

  // Keeps cfg_vld high across the whole first sequence; only the cfg_rdy cycle may accept again.
  task automatic test_back_to_back();
    int done_c;
    cfg_if.cfg_pin = 5'd15;
    cfg_if.cfg_sel = 2'b01;
    cfg_if.cfg_vld = 1'b1;
    tick();
    cfg_if.cfg_sel = 2'b11;
    for (int c = 1; c <= 11; c++) begin
      if (c == 6) begin
        n_vec++; if (fun_sel_vec !== 32'h4000_0080) begin n_err++; $display("FAIL b2b_sel1: got %h expected %h", fun_sel_vec, 32'h4000_0080); end
      end
      if (c == 10) begin
        n_vec++; if ({cfg_if.cfg_done, cfg_if.cfg_rdy, oe_gate_vec[15]} !== 3'b111) begin n_err++; $display("FAIL b2b_end1: got %b expected 111", {cfg_if.cfg_done, cfg_if.cfg_rdy, oe_gate_vec[15]}); end
      end
      if (c == 11) begin
        n_vec++; if ({busy, cfg_if.cfg_rdy, oe_gate_vec[15]} !== 3'b100) begin n_err++; $display("FAIL b2b_start2: got %b expected 100", {busy, cfg_if.cfg_rdy, oe_gate_vec[15]}); end
      end
      if (c < 11) tick();
    end
    cfg_if.cfg_vld = 1'b0;
    done_c = 0;
    for (int c = 11; c <= 60; c++) begin
      if (cfg_if.cfg_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    n_vec++; if (done_c != 20) begin n_err++; $display("FAIL b2b_done2_cycle: got %0d expected 20", done_c); end
    n_vec++; if (fun_sel_vec !== 32'hC000_0080) begin n_err++; $display("FAIL b2b_sel2: got %h expected %h", fun_sel_vec, 32'hC000_0080); end
    n_vec++; if (oe_gate_vec !== 16'hFFFF) begin n_err++; $display("FAIL b2b_gate2: got %h expected %h", oe_gate_vec, 16'hFFFF); end
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    send(5'd2, 2'b11);
    repeat (6) tick();
    n_vec++; if (fun_sel_vec !== 32'hC000_00B0) begin n_err++; $display("FAIL mid_settle_sel: got %h expected %h", fun_sel_vec, 32'hC000_00B0); end
    n_vec++; if ({busy, oe_gate_vec[2]} !== 2'b10) begin n_err++; $display("FAIL mid_settle_state: got %b expected 10", {busy, oe_gate_vec[2]}); end
    rst = 1'b1;
    seen_done = 1'b0;
    tick();
    n_vec++; if (fun_sel_vec !== 32'h0) begin n_err++; $display("FAIL mid_sel: got %h expected %h", fun_sel_vec, 32'h0); end
    n_vec++; if (oe_gate_vec !== 16'hFFFF) begin n_err++; $display("FAIL mid_gate: got %h expected %h", oe_gate_vec, 16'hFFFF); end
    n_vec++; if ({busy, cfg_if.cfg_rdy, cfg_if.cfg_err} !== 3'b000) begin n_err++; $display("FAIL mid_flags: got %b expected 000", {busy, cfg_if.cfg_rdy, cfg_if.cfg_err}); end
    seen_done |= cfg_if.cfg_done;
    tick();
    seen_done |= cfg_if.cfg_done;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_done |= cfg_if.cfg_done;
    end
    n_vec++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got %b expected 0", seen_done); end
    n_vec++; if (cfg_if.cfg_rdy !== 1'b1) begin n_err++; $display("FAIL mid_rdy: got %b expected 1", cfg_if.cfg_rdy); end
  endtask

`ifdef IO_MUX_CFG_LOCK_EN
  task automatic test_lock();
    int done_c;
    cfg_lock = 1'b1;
    tick();
    cfg_lock = 1'b0;
    tick();
    send(5'd0, 2'b01);
    n_vec++; if (cfg_if.cfg_err !== 1'b1) begin n_err++; $display("FAIL lock_err: got %b expected 1", cfg_if.cfg_err); end
    n_vec++; if ({busy, oe_gate_vec[0]} !== 2'b01) begin n_err++; $display("FAIL lock_state: got %b expected 01", {busy, oe_gate_vec[0]}); end
    tick();
    n_vec++; if (fun_sel_vec !== 32'h0) begin n_err++; $display("FAIL lock_sel: got %h expected %h", fun_sel_vec, 32'h0); end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    send(5'd0, 2'b01);
    n_vec++; if ({busy, cfg_if.cfg_err, oe_gate_vec[0]} !== 3'b100) begin n_err++; $display("FAIL unlock_start: got %b expected 100", {busy, cfg_if.cfg_err, oe_gate_vec[0]}); end
    done_c = 0;
    for (int c = 1; c <= 40; c++) begin
      if (cfg_if.cfg_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    n_vec++; if (done_c != 10) begin n_err++; $display("FAIL unlock_done_cycle: got %0d expected 10", done_c); end
    n_vec++; if (fun_sel_vec !== 32'h1) begin n_err++; $display("FAIL unlock_sel: got %h expected %h", fun_sel_vec, 32'h1); end
  endtask
`endif

  initial begin
    cfg_if.cfg_vld = 1'b0;
    cfg_if.cfg_pin = '0;
    cfg_if.cfg_sel = '0;
    test_reset();
    test_switch();
    test_same_sel();
    test_bad_pin();
    test_readback();
    test_back_to_back();
    test_reset_mid();
`ifdef IO_MUX_CFG_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
